// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch: boot ROM first, then external SRAM after boot_done.
// Owns the PC and hands one registered instruction at a time to the CPU.
//
// state | meaning
// FETCH | select source; ROM data captured here, or start an SRAM request
// REQ   | ram_req high, waiting for ram_ack or timeout
// VALID | cpu_instruction presented, waiting for cpu_next
module hack_fetch #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          ACK_TIMEOUT   = 255,
  parameter logic [15:0] TIMEOUT_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] rom_pc,
  input  logic [15:0] rom_instruction,
  output logic [15:0] ram_addr,
  output logic        ram_req,
  input  logic        ram_ack,
  input  logic [15:0] ram_data,
  input  logic        boot_done,
  output logic [15:0] cpu_instruction,
  output logic        cpu_valid,
  input  logic        cpu_next,
  input  logic        cpu_load,
  input  logic [15:0] cpu_target,
  output logic [15:0] pc,
  output logic        ram_mode,
  output logic        fetch_err
);

  typedef enum logic [1:0] {FETCH, REQ, VALID} state_t;

  localparam logic [15:0] TC = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      ram_mode        <= 1'b0;
      cpu_instruction <= 16'h0000;
      fetch_err       <= 1'b0;
      cnt             <= 16'h0000;
    end else if (boot_done && !ram_mode) begin
      // boot switch overrides whatever the fetch loop was doing
      ram_mode <= 1'b1;
      pc       <= RESET_PC;
      state    <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (!ram_mode) begin
            cpu_instruction <= rom_instruction;
            state           <= VALID;
          end else begin
            cnt   <= 16'h0000;
            state <= REQ;
          end
        end
        REQ: begin
          if (ram_ack) begin
            cpu_instruction <= ram_data;
            state           <= VALID;
          end else if (cnt == TC) begin
            cpu_instruction <= TIMEOUT_INSTR;
            fetch_err       <= 1'b1;
            state           <= VALID;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        VALID: begin
          if (cpu_next) begin
            pc    <= cpu_load ? cpu_target : pc + 16'd1;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign rom_pc    = pc;
  assign ram_addr  = pc;
  assign ram_req   = (state == REQ);
  assign cpu_valid = (state == VALID);

endmodule
